// File: rtl/job_seq_pkg.sv
// Shared types, address map and byte counts for the job sequencer.
package job_seq_pkg;

    typedef enum logic [1:0] {
        PROG_RECIP   = 2'd0,
        PROG_DIV     = 2'd1,
        PROG_SQRT    = 2'd2,
        PROG_INVALID = 2'd3
    } prog_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_READ  = 3'd4,
        ST_RESP  = 3'd5
    } state_e;

    // Data-memory layout shared with the CPU firmware
    localparam logic [7:0] RECIP_OP_BASE  = 8'd8;
    localparam logic [7:0] RECIP_RES_BASE = 8'd10;
    localparam logic [7:0] DIV_OP_BASE    = 8'd0;
    localparam logic [7:0] DIV_RES_BASE   = 8'd4;
    localparam logic [7:0] SQRT_OP_BASE   = 8'd16;
    localparam logic [7:0] SQRT_RES_BASE  = 8'd18;

    localparam logic [1:0] RECIP_OP_BYTES  = 2'd2;
    localparam logic [1:0] RECIP_RES_BYTES = 2'd2;
    localparam logic [1:0] DIV_OP_BYTES    = 2'd3;
    localparam logic [1:0] DIV_RES_BYTES   = 2'd3;
    localparam logic [1:0] SQRT_OP_BYTES   = 2'd2;
    localparam logic [1:0] SQRT_RES_BYTES  = 2'd1;

    function automatic logic [7:0] op_base(input prog_e prog);
        case (prog)
            PROG_RECIP: op_base = RECIP_OP_BASE;
            PROG_DIV:   op_base = DIV_OP_BASE;
            PROG_SQRT:  op_base = SQRT_OP_BASE;
            default:    op_base = 8'd0;
        endcase
    endfunction

    function automatic logic [7:0] res_base(input prog_e prog);
        case (prog)
            PROG_RECIP: res_base = RECIP_RES_BASE;
            PROG_DIV:   res_base = DIV_RES_BASE;
            PROG_SQRT:  res_base = SQRT_RES_BASE;
            default:    res_base = 8'd0;
        endcase
    endfunction

    function automatic logic [1:0] op_bytes(input prog_e prog);
        case (prog)
            PROG_RECIP: op_bytes = RECIP_OP_BYTES;
            PROG_DIV:   op_bytes = DIV_OP_BYTES;
            PROG_SQRT:  op_bytes = SQRT_OP_BYTES;
            default:    op_bytes = 2'd0;
        endcase
    endfunction

    function automatic logic [1:0] res_bytes(input prog_e prog);
        case (prog)
            PROG_RECIP: res_bytes = RECIP_RES_BYTES;
            PROG_DIV:   res_bytes = DIV_RES_BYTES;
            PROG_SQRT:  res_bytes = SQRT_RES_BYTES;
            default:    res_bytes = 2'd0;
        endcase
    endfunction

    // Operand bytes go out most significant first; the divisor trails OpA
    function automatic logic [7:0] op_byte(input logic [1:0] idx,
                                           input logic [15:0] opa,
                                           input logic [7:0] opb);
        case (idx)
            2'd0:    op_byte = opa[15:8];
            2'd1:    op_byte = opa[7:0];
            2'd2:    op_byte = opb;
            default: op_byte = 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/job_seq_timer.sv
// WAIT-phase timeout counter: counts enabled cycles, flags the last one.
module job_seq_timer #(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_q;

    // Next count: clear wins, otherwise advance while enabled, saturating at LAST
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = enable && !clear && (cnt_q == LAST);

endmodule

// File: rtl/job_sequencer.sv
// Job sequencer: loads operands into CPU data memory, launches the CPU,
// waits for completion or timeout, reads back the result and hands it out.
module job_sequencer
    import job_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int START_CYCLES   = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        JobValid,
    output logic        JobReady,
    input  logic [1:0]  JobProg,
    input  logic [15:0] JobOpA,
    input  logic [7:0]  JobOpB,
    output logic        CpuStart,
    input  logic        CpuAck,
    output logic        DmWrEn,
    output logic [7:0]  DmAddr,
    output logic [7:0]  DmWrData,
    input  logic [7:0]  DmRdData,
    output logic        ResValid,
    input  logic        ResReady,
    output logic [23:0] ResData,
    output logic [1:0]  ResProg,
    output logic        ResErr,
    output logic        Busy
);

    localparam int SW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
    localparam logic [SW-1:0] START_LAST = SW'(START_CYCLES - 1);

    state_e        state_d, state_q;
    prog_e         prog_d, prog_q;
    logic [15:0]   opa_d, opa_q;
    logic [7:0]    opb_d, opb_q;
    logic [1:0]    idx_d, idx_q;
    logic [SW-1:0] scnt_d, scnt_q;
    logic [23:0]   res_d, res_q;
    logic          err_d, err_q;

    logic          job_ready_d, job_ready_q;
    logic          cpu_start_d, cpu_start_q;
    logic          dm_wr_en_d, dm_wr_en_q;
    logic [7:0]    dm_addr_d, dm_addr_q;
    logic [7:0]    dm_wr_data_d, dm_wr_data_q;
    logic          res_valid_d, res_valid_q;
    logic [23:0]   res_data_d, res_data_q;
    logic [1:0]    res_prog_d, res_prog_q;
    logic          res_err_d, res_err_q;
    logic          busy_d, busy_q;

    logic          tmr_expired;

    job_seq_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (Clk),
        .rst     (Reset),
        .clear   (state_q != ST_WAIT),
        .enable  (state_q == ST_WAIT),
        .expired (tmr_expired)
    );

    // FSM next state and job context
    always_comb begin
        state_d = state_q;
        prog_d  = prog_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        idx_d   = idx_q;
        scnt_d  = scnt_q;
        res_d   = res_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (JobValid) begin
                    prog_d = prog_e'(JobProg);
                    opa_d  = JobOpA;
                    opb_d  = JobOpB;
                    idx_d  = 2'd0;
                    scnt_d = '0;
                    res_d  = 24'd0;
                    if (prog_e'(JobProg) == PROG_INVALID) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (idx_q == (op_bytes(prog_q) - 2'd1)) begin
                    idx_d   = 2'd0;
                    scnt_d  = '0;
                    state_d = ST_START;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            ST_START: begin
                if (scnt_q == START_LAST) begin
                    scnt_d  = '0;
                    state_d = ST_WAIT;
                end else begin
                    scnt_d = scnt_q + 1'b1;
                end
            end
            ST_WAIT: begin
                // A late Ack still beats the timeout on the final cycle
                if (CpuAck) begin
                    idx_d   = 2'd0;
                    res_d   = 24'd0;
                    state_d = ST_READ;
                end else if (tmr_expired) begin
                    err_d   = 1'b1;
                    res_d   = 24'd0;
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_READ: begin
                // Read data trails its address by one cycle, so capture from idx 1
                if (idx_q != 2'd0) begin
                    res_d = {res_q[15:0], DmRdData};
                end else begin
                    res_d = res_q;
                end
                if (idx_q == res_bytes(prog_q)) begin
                    idx_d   = 2'd0;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            ST_RESP: begin
                if (ResReady) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output values for the upcoming cycle, decoded from the next state
    always_comb begin
        job_ready_d  = (state_d == ST_IDLE);
        busy_d       = (state_d != ST_IDLE);
        cpu_start_d  = (state_d == ST_LOAD) || (state_d == ST_START);
        dm_wr_en_d   = (state_d == ST_LOAD);
        dm_addr_d    = 8'd0;
        dm_wr_data_d = 8'd0;
        if (state_d == ST_LOAD) begin
            dm_addr_d    = op_base(prog_d) + {6'd0, idx_d};
            dm_wr_data_d = op_byte(idx_d, opa_d, opb_d);
        end else if ((state_d == ST_READ) && (idx_d < res_bytes(prog_d))) begin
            dm_addr_d = res_base(prog_d) + {6'd0, idx_d};
        end else begin
            dm_addr_d = 8'd0;
        end
        if (state_d == ST_RESP) begin
            res_valid_d = 1'b1;
            res_data_d  = res_d;
            res_prog_d  = prog_d;
            res_err_d   = err_d;
        end else begin
            res_valid_d = 1'b0;
            res_data_d  = 24'd0;
            res_prog_d  = 2'd0;
            res_err_d   = 1'b0;
        end
    end

    // State, context and output registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            prog_q       <= PROG_RECIP;
            opa_q        <= 16'd0;
            opb_q        <= 8'd0;
            idx_q        <= 2'd0;
            scnt_q       <= '0;
            res_q        <= 24'd0;
            err_q        <= 1'b0;
            job_ready_q  <= 1'b1;
            cpu_start_q  <= 1'b0;
            dm_wr_en_q   <= 1'b0;
            dm_addr_q    <= 8'd0;
            dm_wr_data_q <= 8'd0;
            res_valid_q  <= 1'b0;
            res_data_q   <= 24'd0;
            res_prog_q   <= 2'd0;
            res_err_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            prog_q       <= prog_d;
            opa_q        <= opa_d;
            opb_q        <= opb_d;
            idx_q        <= idx_d;
            scnt_q       <= scnt_d;
            res_q        <= res_d;
            err_q        <= err_d;
            job_ready_q  <= job_ready_d;
            cpu_start_q  <= cpu_start_d;
            dm_wr_en_q   <= dm_wr_en_d;
            dm_addr_q    <= dm_addr_d;
            dm_wr_data_q <= dm_wr_data_d;
            res_valid_q  <= res_valid_d;
            res_data_q   <= res_data_d;
            res_prog_q   <= res_prog_d;
            res_err_q    <= res_err_d;
            busy_q       <= busy_d;
        end
    end

    assign JobReady = job_ready_q;
    assign CpuStart = cpu_start_q;
    assign DmWrEn   = dm_wr_en_q;
    assign DmAddr   = dm_addr_q;
    assign DmWrData = dm_wr_data_q;
    assign ResValid = res_valid_q;
    assign ResData  = res_data_q;
    assign ResProg  = res_prog_q;
    assign ResErr   = res_err_q;
    assign Busy     = busy_q;

endmodule

// File: tb/tb_job_sequencer.sv
// Randomized self-checking bench for job_sequencer with a behavioural
// data-memory / CPU model and a table-driven reference for writes and results.
module tb_job_sequencer;

    localparam int TMO = 16;
    localparam int STC = 2;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        JobValid;
    logic        JobReady;
    logic [1:0]  JobProg;
    logic [15:0] JobOpA;
    logic [7:0]  JobOpB;
    logic        CpuStart;
    logic        CpuAck;
    logic        DmWrEn;
    logic [7:0]  DmAddr;
    logic [7:0]  DmWrData;
    logic [7:0]  DmRdData = 8'h00;
    logic        ResValid;
    logic        ResReady;
    logic [23:0] ResData;
    logic [1:0]  ResProg;
    logic        ResErr;
    logic        Busy;

    job_sequencer #(.TIMEOUT_CYCLES(TMO), .START_CYCLES(STC)) dut (
        .Clk(Clk), .Reset(Reset), .JobValid(JobValid), .JobReady(JobReady),
        .JobProg(JobProg), .JobOpA(JobOpA), .JobOpB(JobOpB),
        .CpuStart(CpuStart), .CpuAck(CpuAck), .DmWrEn(DmWrEn),
        .DmAddr(DmAddr), .DmWrData(DmWrData), .DmRdData(DmRdData),
        .ResValid(ResValid), .ResReady(ResReady), .ResData(ResData),
        .ResProg(ResProg), .ResErr(ResErr), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    int n_total = 0;
    int n_bad   = 0;

    // Result bytes the "CPU" leaves in data memory (written only by stimulus)
    logic [7:0] dm_img [0:255];
    // Logged DM writes and CpuStart-high cycles
    logic [7:0] wr_addr [0:4095];
    logic [7:0] wr_data [0:4095];
    int wr_n    = 0;
    int start_n = 0;

    // Data-memory model: synchronous read, write logging, launch counting
    always @(posedge Clk) begin
        DmRdData <= dm_img[DmAddr];
        if (DmWrEn === 1'b1) begin
            wr_addr[wr_n % 4096] <= DmAddr;
            wr_data[wr_n % 4096] <= DmWrData;
            wr_n <= wr_n + 1;
        end
        if (CpuStart === 1'b1) start_n <= start_n + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference tables: program -> memory layout
    function automatic int n_op(input int p);
        case (p)
            0: return 2;
            1: return 3;
            2: return 2;
            default: return 0;
        endcase
    endfunction

    function automatic int n_res(input int p);
        case (p)
            0: return 2;
            1: return 3;
            2: return 1;
            default: return 0;
        endcase
    endfunction

    function automatic int op_addr(input int p, input int i);
        case (p)
            0: return 8 + i;
            1: return 0 + i;
            2: return 16 + i;
            default: return 0;
        endcase
    endfunction

    function automatic int res_addr(input int p, input int i);
        case (p)
            0: return 10 + i;
            1: return 4 + i;
            2: return 18 + i;
            default: return 0;
        endcase
    endfunction

    function automatic int exp_wbyte(input int i, input int opa, input int opb);
        if (i == 0) return (opa / 256) % 256;
        if (i == 1) return opa % 256;
        return opb % 256;
    endfunction

    function automatic int exp_result(input int p);
        int acc = 0;
        for (int i = 0; i < n_res(p); i++) acc = acc * 256 + int'(dm_img[res_addr(p, i)]);
        return acc;
    endfunction

    task automatic check_all_zero(input string pfx);
        check({pfx, "_cpustart"}, 32'(CpuStart), 32'd0);
        check({pfx, "_dmwren"},   32'(DmWrEn),   32'd0);
        check({pfx, "_resvalid"}, 32'(ResValid), 32'd0);
        check({pfx, "_reserr"},   32'(ResErr),   32'd0);
        check({pfx, "_busy"},     32'(Busy),     32'd0);
        check({pfx, "_resdata"},  32'(ResData),  32'd0);
        check({pfx, "_resprog"},  32'(ResProg),  32'd0);
        check({pfx, "_dmaddr"},   32'(DmAddr),   32'd0);
        check({pfx, "_dmwdata"},  32'(DmWrData), 32'd0);
    endtask

    // Offer one job (DUT must be idle) at a negedge; returns after the accept edge
    task automatic offer(input int p, input int opa, input int opb);
        check("ready_idle", 32'(JobReady), 32'd1);
        JobValid = 1'b1;
        JobProg  = 2'(p);
        JobOpA   = 16'(opa);
        JobOpB   = 8'(opb);
        @(negedge Clk);
        JobValid = 1'b0;
        JobProg  = 2'($urandom_range(0, 3));
        JobOpA   = 16'($urandom);
        JobOpB   = 8'($urandom);
        check("ready_after_accept", 32'(JobReady), 32'd0);
    endtask

    task automatic run_job(input int p, input int opa, input int opb, input int ack_dly,
                           input bit no_ack, input int hold, input bit rnd_mem);
        int w0, s0, cyc, exp_res;
        bit exp_err;
        if (rnd_mem) begin
            for (int i = 0; i < n_res(p); i++) dm_img[res_addr(p, i)] = 8'($urandom);
        end
        w0 = wr_n;
        s0 = start_n;
        offer(p, opa, opb);
        if (p == 3) begin
            exp_err = 1'b1;
            exp_res = 0;
            check("inv_valid_next", 32'(ResValid), 32'd1);
        end else begin
            cyc = 0;
            while (CpuStart === 1'b1 && cyc < 64) begin
                @(negedge Clk);
                cyc++;
            end
            check("start_cycles", 32'(start_n - s0), 32'(n_op(p) + STC));
            check("wr_count", 32'(wr_n - w0), 32'(n_op(p)));
            for (int i = 0; i < n_op(p); i++) begin
                check("wr_addr", 32'(wr_addr[(w0 + i) % 4096]), 32'(op_addr(p, i)));
                check("wr_data", 32'(wr_data[(w0 + i) % 4096]), 32'(exp_wbyte(i, opa, opb)));
            end
            check("wait_busy", 32'(Busy), 32'd1);
            if (no_ack) begin
                cyc = 0;
                while (ResValid !== 1'b1 && cyc < 64) begin
                    @(negedge Clk);
                    cyc++;
                end
                check("timeout_latency", 32'(cyc), 32'(TMO));
                exp_err = 1'b1;
                exp_res = 0;
            end else begin
                repeat (ack_dly) @(negedge Clk);
                check("no_early_resp", 32'(ResValid), 32'd0);
                CpuAck = 1'b1;
                @(negedge Clk);
                CpuAck = 1'b0;
                cyc = 1;
                while (ResValid !== 1'b1 && cyc < 64) begin
                    @(negedge Clk);
                    cyc++;
                end
                check("read_latency", 32'(cyc), 32'(n_res(p) + 2));
                exp_err = 1'b0;
                exp_res = exp_result(p);
            end
        end
        // Response held until consumer handshake; Ack noise must be ignored
        for (int h = 0; h <= hold; h++) begin
            ResReady = (h == hold);
            CpuAck   = 1'($urandom_range(0, 1));
            check("resp_valid", 32'(ResValid), 32'd1);
            check("resp_data",  32'(ResData),  32'(exp_res));
            check("resp_prog",  32'(ResProg),  32'(p));
            check("resp_err",   32'(ResErr),   32'(exp_err));
            check("resp_ready", 32'(JobReady), 32'd0);
            check("resp_nowr",  32'(DmWrEn),   32'd0);
            @(negedge Clk);
        end
        ResReady = 1'b0;
        CpuAck   = 1'b0;
        check("post_valid", 32'(ResValid), 32'd0);
        check("post_ready", 32'(JobReady), 32'd1);
        check("post_busy",  32'(Busy),     32'd0);
        if (p == 3) check("inv_no_write", 32'(wr_n - w0), 32'd0);
    endtask

    // Reset pulsed mid-job (phase 0: LOAD, 1: WAIT); job must vanish
    task automatic reset_mid(input int phase);
        int p, cyc, seen;
        p = $urandom_range(0, 2);
        offer(p, int'($urandom_range(0, 65535)), int'($urandom_range(0, 255)));
        if (phase == 1) begin
            cyc = 0;
            while (CpuStart === 1'b1 && cyc < 64) begin
                @(negedge Clk);
                cyc++;
            end
            repeat (3) @(negedge Clk);
            check("pre_reset_busy", 32'(Busy), 32'd1);
        end else begin
            check("pre_reset_load", 32'(DmWrEn), 32'd1);
        end
        #2 Reset = 1'b1;
        #1 check_all_zero(phase == 1 ? "rst_wait" : "rst_load");
        @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        check("rst_release_ready", 32'(JobReady), 32'd1);
        CpuAck = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            if (i == 2) CpuAck = 1'b0;
            if (ResValid === 1'b1) seen++;
        end
        check("rst_no_result", 32'(seen), 32'd0);
        check("rst_idle_busy", 32'(Busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) dm_img[i] = 8'h00;
        Reset    = 1'b1;
        JobValid = 1'b0;
        JobProg  = 2'd0;
        JobOpA   = 16'd0;
        JobOpB   = 8'd0;
        CpuAck   = 1'b0;
        ResReady = 1'b0;
        repeat (2) @(negedge Clk);
        check_all_zero("reset");
        Reset = 1'b0;
        @(negedge Clk);
        check("reset_ready", 32'(JobReady), 32'd1);

        // Directed vectors
        dm_img[10] = 8'h20; dm_img[11] = 8'h00;
        run_job(0, 16'h0004, 8'h00, 10, 1'b0, 0, 1'b0);
        dm_img[4] = 8'h03; dm_img[5] = 8'h03; dm_img[6] = 8'h03;
        run_job(1, 16'h0003, 8'hFF, 5, 1'b0, 2, 1'b0);
        dm_img[18] = 8'h09;
        run_job(2, 16'h0051, 8'h00, 3, 1'b0, 1, 1'b0);
        run_job(0, 16'h1234, 8'h00, 0, 1'b1, 0, 1'b1);
        run_job(3, 16'hBEEF, 8'h55, 0, 1'b0, 0, 1'b1);
        run_job(1, 16'h0000, 8'h00, 0, 1'b0, 5, 1'b1);
        run_job(1, 16'hFFFF, 8'h00, 12, 1'b0, 0, 1'b1);
        reset_mid(1);
        reset_mid(0);

        // Randomized jobs
        for (int k = 0; k < 40; k++) begin
            run_job(int'($urandom_range(0, 3)), int'($urandom_range(0, 65535)),
                    int'($urandom_range(0, 255)), int'($urandom_range(0, 12)),
                    ($urandom_range(0, 7) == 0), int'($urandom_range(0, 5)), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
